// File: rtl/object_mover.sv
// Moves a point one velocity step per frame tick, limiting each axis to [0, MAX].
// Define OBJECT_MOVER_BOUNCE_EN to also reverse an axis velocity when that axis is limited.
module object_mover #(
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479,
   parameter int POS_BITS = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick_in,
   output logic                       tick_clr,
   input  logic                       enable,
   input  logic                       load,
   input  logic        [POS_BITS-1:0] load_x,
   input  logic        [POS_BITS-1:0] load_y,
   input  logic signed [3:0]          vel_x,
   input  logic signed [3:0]          vel_y,
   output logic        [POS_BITS-1:0] pos_x,
   output logic        [POS_BITS-1:0] pos_y,
   output logic                       update_done,
   output logic                       hit_edge
);

   localparam int SUM_W = POS_BITS + 2;
   localparam logic signed [SUM_W-1:0] X_LIM = SUM_W'(X_MAX);
   localparam logic signed [SUM_W-1:0] Y_LIM = SUM_W'(Y_MAX);

   typedef enum logic [2:0] {IDLE, ACK, CALC_X, CALC_Y, DONE} state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic        [POS_BITS-1:0] r_pos_x;
   logic        [POS_BITS-1:0] r_pos_y;
   logic signed [3:0]          r_vel_x;
   logic signed [3:0]          r_vel_y;
   logic                       r_lim_x;
   logic                       r_lim_y;
   logic        [POS_BITS:0]   w_x_res;
   logic        [POS_BITS:0]   w_y_res;

   // Result is {limited_flag, new_position}.
   function automatic logic [POS_BITS:0] clamp_axis(
      input logic        [POS_BITS-1:0] pos,
      input logic signed [3:0]          vel,
      input logic signed [SUM_W-1:0]    lim
   );
      logic signed [SUM_W-1:0] sum;
      sum = $signed({2'b00, pos}) + $signed({{(SUM_W-4){vel[3]}}, vel});
      if (vel == 4'sd0)
         clamp_axis = {1'b0, pos};
      else if (sum[SUM_W-1])
         clamp_axis = {1'b1, {POS_BITS{1'b0}}};
      else if (sum > lim)
         clamp_axis = {1'b1, lim[POS_BITS-1:0]};
      else
         clamp_axis = {1'b0, sum[POS_BITS-1:0]};
   endfunction

`ifdef OBJECT_MOVER_BOUNCE_EN
   // -8 has no positive counterpart in 4 bits; it reverses to +7.
   function automatic logic signed [3:0] negate_vel(input logic signed [3:0] v);
      negate_vel = (v == -4'sd8) ? 4'sd7 : -v;
   endfunction
`endif

   assign w_x_res = clamp_axis(r_pos_x, r_vel_x, X_LIM);
   assign w_y_res = clamp_axis(r_pos_y, r_vel_y, Y_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_pos_x <= '0;
         r_pos_y <= '0;
         r_vel_x <= '0;
         r_vel_y <= '0;
         r_lim_x <= 1'b0;
         r_lim_y <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (load) begin
            r_pos_x <= load_x;
            r_pos_y <= load_y;
            r_vel_x <= vel_x;
            r_vel_y <= vel_y;
            r_lim_x <= 1'b0;
            r_lim_y <= 1'b0;
         end else if (r_state == CALC_X) begin
            r_pos_x <= w_x_res[POS_BITS-1:0];
            r_lim_x <= w_x_res[POS_BITS];
`ifdef OBJECT_MOVER_BOUNCE_EN
            if (w_x_res[POS_BITS]) r_vel_x <= negate_vel(r_vel_x);
`endif
         end else if (r_state == CALC_Y) begin
            r_pos_y <= w_y_res[POS_BITS-1:0];
            r_lim_y <= w_y_res[POS_BITS];
`ifdef OBJECT_MOVER_BOUNCE_EN
            if (w_y_res[POS_BITS]) r_vel_y <= negate_vel(r_vel_y);
`endif
         end
      end
   end

   // Pulses are decoded from the state and suppressed while load is high.
   always_comb begin
      w_next_state = r_state;
      tick_clr     = 1'b0;
      update_done  = 1'b0;
      hit_edge     = 1'b0;
      if (load) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (tick_in && enable) w_next_state = ACK;
            ACK: begin
               tick_clr     = 1'b1;
               w_next_state = CALC_X;
            end
            CALC_X:  w_next_state = CALC_Y;
            CALC_Y:  w_next_state = DONE;
            DONE: begin
               update_done  = 1'b1;
               hit_edge     = r_lim_x | r_lim_y;
               w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   assign pos_x = r_pos_x;
   assign pos_y = r_pos_y;

endmodule

// File: tb/tb_object_mover.sv
// Bench for object_mover: fixed vector table, multi-cycle corner sequences and
// randomized tick runs against an integer model of the movement rules.
module tb_object_mover;

   localparam int XM = 639;
   localparam int YM = 479;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              tick_in = 1'b0;
   logic              tick_clr;
   logic              enable = 1'b1;
   logic              load = 1'b0;
   logic        [9:0] load_x = '0;
   logic        [9:0] load_y = '0;
   logic signed [3:0] vel_x = '0;
   logic signed [3:0] vel_y = '0;
   logic        [9:0] pos_x;
   logic        [9:0] pos_y;
   logic              update_done;
   logic              hit_edge;

   int n_vec = 0;
   int n_err = 0;

   object_mover #(.X_MAX(XM), .Y_MAX(YM), .POS_BITS(10)) dut (
      .clk(clk), .reset(reset), .tick_in(tick_in), .tick_clr(tick_clr),
      .enable(enable), .load(load), .load_x(load_x), .load_y(load_y),
      .vel_x(vel_x), .vel_y(vel_y), .pos_x(pos_x), .pos_y(pos_y),
      .update_done(update_done), .hit_edge(hit_edge)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lx; int ly; int vx; int vy;
      int ex; int ey; int eh;
   } vec_t;

   task automatic chk(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Integer model of one axis update.
   function automatic void model_axis(inout int p, inout int v, input int mx, output int lim);
      int s;
      lim = 0;
      if (v == 0) return;
      s = p + v;
      if (s < 0) begin
         p = 0; lim = 1;
      end else if (s > mx) begin
         p = mx; lim = 1;
      end else begin
         p = s;
      end
`ifdef OBJECT_MOVER_BOUNCE_EN
      if (lim != 0) v = (v == -8) ? 7 : -v;
`endif
   endfunction

   task automatic do_load(input int lx, input int ly, input int vx, input int vy);
      @(negedge clk);
      load = 1'b1; load_x = 10'(lx); load_y = 10'(ly);
      vel_x = 4'(vx); vel_y = 4'(vy);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Raises a tick in an idle cycle and follows it to update_done (bounded).
   task automatic run_tick(output int clr_n, output int clr_cnt, output int done_n,
                           output int gx, output int gy, output int gh);
      clr_n = -1; clr_cnt = 0; done_n = -1; gx = -1; gy = -1; gh = -1;
      @(negedge clk);
      tick_in = 1'b1; enable = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (tick_clr) begin
            clr_cnt++;
            if (clr_n < 0) clr_n = n;
            tick_in = 1'b0;
         end
         if (update_done) begin
            done_n = n; gx = int'(pos_x); gy = int'(pos_y); gh = int'(hit_edge);
            break;
         end
      end
      tick_in = 1'b0;
   endtask

   task automatic tick_and_check(input string nm, input int ex, input int ey, input int eh);
      int cn, cc, dn, gx, gy, gh;
      run_tick(cn, cc, dn, gx, gy, gh);
      chk({nm, " clr_cycle"}, cn, 1);
      chk({nm, " clr_width"}, cc, 1);
      chk({nm, " done_latency"}, dn, 4);
      chk({nm, " pos_x"}, gx, ex);
      chk({nm, " pos_y"}, gy, ey);
      chk({nm, " hit_edge"}, gh, eh);
   endtask

   initial begin
      vec_t tbl[8];
      int   c_clr, c_done, sx, sy;
      int   mx, my, mvx, mvy, lx_, ly_, limx, limy;

      tbl[0] = '{100, 200,  3, -2, 103, 198, 0};
      tbl[1] = '{637,   5,  5, -7, 639,   0, 1};
      tbl[2] = '{  0,   0, -1,  0,   0,   0, 1};
      tbl[3] = '{639, 479,  0,  0, 639, 479, 0};
      tbl[4] = '{639, 479,  7,  7, 639, 479, 1};
      tbl[5] = '{  1, 478, -1,  1,   0, 479, 0};
      tbl[6] = '{  0,   0, -8, -8,   0,   0, 1};
      tbl[7] = '{320, 240,  7, -8, 327, 232, 0};

      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset outputs", int'({pos_x, pos_y, tick_clr, update_done, hit_edge}), 0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_load(tbl[i].lx, tbl[i].ly, tbl[i].vx, tbl[i].vy);
         tick_and_check($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].eh);
      end

      // Second tick after hitting both edges.
      do_load(637, 5, 5, -7);
      tick_and_check("edge1", 639, 0, 1);
`ifdef OBJECT_MOVER_BOUNCE_EN
      tick_and_check("edge2", 634, 7, 0);
`else
      tick_and_check("edge2", 639, 0, 1);
`endif

      // Held tick blocked by enable=0, then served exactly once.
      do_load(10, 10, 1, 1);
      @(negedge clk);
      enable = 1'b0; tick_in = 1'b1; c_clr = 0; c_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (tick_clr) c_clr++;
         if (update_done) c_done++;
      end
      chk("gated clr", c_clr, 0);
      chk("gated done", c_done, 0);
      enable = 1'b1; sx = -1; sy = -1;
      repeat (12) begin
         @(negedge clk);
         if (tick_clr) begin c_clr++; tick_in = 1'b0; end
         if (update_done) begin c_done++; sx = int'(pos_x); sy = int'(pos_y); end
      end
      tick_in = 1'b0;
      chk("enable clr", c_clr, 1);
      chk("enable done", c_done, 1);
      chk("enable pos_x", sx, 11);
      chk("enable pos_y", sy, 11);

      // Load during CALC_X aborts the update; held tick is served afterwards.
      do_load(50, 60, 2, 2);
      @(negedge clk);
      tick_in = 1'b1; enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      load = 1'b1; load_x = 10'd200; load_y = 10'd300; vel_x = -4'sd1; vel_y = -4'sd1;
      chk("midload pulse", int'({tick_clr, update_done, hit_edge}), 0);
      @(posedge clk); #1;
      chk("midload pos_x", int'(pos_x), 200);
      chk("midload pos_y", int'(pos_y), 300);
      chk("midload done", int'(update_done), 0);
      load = 1'b0;
      tick_and_check("pending", 199, 299, 0);

      // Reset in CALC_Y.
      do_load(100, 100, 1, 1);
      @(negedge clk);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset pos_x", int'(pos_x), 101);
      reset = 1'b1;
      #1;
      chk("midreset outputs", int'({pos_x, pos_y, tick_clr, update_done, hit_edge}), 0);
      @(negedge clk);
      reset = 1'b0; c_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (update_done) c_done++;
      end
      chk("midreset done", c_done, 0);

      // Randomized loads and tick runs against the model.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0:       begin lx_ = int'($urandom_range(0, 7)); ly_ = int'($urandom_range(0, 7)); end
            1:       begin lx_ = XM - int'($urandom_range(0, 7)); ly_ = YM - int'($urandom_range(0, 7)); end
            default: begin lx_ = int'($urandom_range(0, XM)); ly_ = int'($urandom_range(0, YM)); end
         endcase
         mvx = int'($urandom_range(0, 15)) - 8;
         mvy = int'($urandom_range(0, 15)) - 8;
         mx = lx_; my = ly_;
         do_load(mx, my, mvx, mvy);
         repeat ($urandom_range(1, 3)) begin
            model_axis(mx, mvx, XM, limx);
            model_axis(my, mvy, YM, limy);
            tick_and_check($sformatf("rand%0d", it), mx, my, (limx | limy) != 0 ? 1 : 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
